// File: rtl/rs_issue_scheduler_pkg.sv
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared scheduler types: lane enumeration and RS sizing constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  // Execution lane selector; also used as the lane index inside the scheduler.
  typedef enum logic {
    lane_alu = 1'b0,
    lane_cmp = 1'b1
  } sched_lane_e;

  // Default number of reservation-station entries tracked by the scheduler.
  localparam int RS_SIZE = 8;

  // Number of execution lanes fed by the scheduler.
  localparam int SCHED_LANES = 2;

endpackage : rv32i_types

`default_nettype wire

// File: rtl/rs_issue_scheduler_picker.sv
// ============================================================================
// Module   : oldest_picker
// Purpose  : Combinational age-matrix select. Returns the candidate that no
//            other candidate is older than; falls back to the lowest-index
//            candidate if the matrix is inconsistent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module oldest_picker
  import rv32i_types::*;
#(
  parameter int SIZE  = RS_SIZE,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]            cand,
  input  logic [SIZE-1:0][SIZE-1:0]  older,
  output logic                       any,
  output logic [IDX_W-1:0]           idx
);

  logic [SIZE-1:0] win;
  logic [SIZE-1:0] pool;

  // An entry wins when it is a candidate and no other candidate is older.
  always_comb begin
    win = '0;
    for (int i = 0; i < SIZE; i++) begin
      win[i] = cand[i];
      for (int j = 0; j < SIZE; j++) begin
        if (cand[j] && older[j][i]) begin
          win[i] = 1'b0;
        end
      end
    end
  end

  // Encode the lowest-index winner; a corrupted matrix can leave no winner,
  // in which case the lowest-index candidate is used instead.
  always_comb begin
    pool = (|win) ? win : cand;
    idx  = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (pool[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign any = |cand;

endmodule : oldest_picker

`default_nettype wire

// File: rtl/rs_issue_scheduler.sv
// ============================================================================
// Module   : rs_issue_scheduler
// Purpose  : Oldest-first issue scheduler feeding one ALU lane and one CMP
//            lane from the reservation-station array. Keeps an age matrix of
//            RS allocations, offers the oldest ready entry per lane through a
//            registered valid/ready handshake and marks accepted entries as
//            in-flight until the RS frees the slot.
// Options  : SCHED_PERF_EN - adds perf_issued / perf_alu_stall /
//            perf_cmp_stall event counters (cleared by rst only).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_scheduler
  import rv32i_types::*;
#(
  parameter int SIZE  = RS_SIZE,
  parameter int IDX_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  logic [SIZE-1:0]   entry_valid,
  input  logic [SIZE-1:0]   entry_ready,
  input  logic [SIZE-1:0]   entry_cmp,
  output logic              alu_issue_valid,
  output logic [IDX_W-1:0]  alu_issue_idx,
  input  logic              alu_issue_ready,
  output logic              cmp_issue_valid,
  output logic [IDX_W-1:0]  cmp_issue_idx,
  input  logic              cmp_issue_ready,
  output logic [SIZE-1:0]   inflight
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_alu_stall,
  output logic [31:0]       perf_cmp_stall
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  // older[i][j] = 1 when entry i was allocated before entry j.
  logic [SIZE-1:0][SIZE-1:0]         older;
  logic [SIZE-1:0][SIZE-1:0]         older_nxt;
  logic [SIZE-1:0]                   inflight_nxt;

  // Per-lane views, indexed by sched_lane_e (bit 0 = ALU, bit 1 = CMP).
  logic [SCHED_LANES-1:0]            lane_ready;
  logic [SCHED_LANES-1:0]            lane_valid;
  logic [SCHED_LANES-1:0]            lane_accept;
  logic [SCHED_LANES-1:0][IDX_W-1:0] lane_idx;

  assign lane_ready = {cmp_issue_ready, alu_issue_ready};

  // A new allocation is younger than every currently valid entry and older
  // than nothing; its row is cleared and its column marks the live entries.
  always_comb begin
    older_nxt = older;
    if (alloc) begin
      for (int j = 0; j < SIZE; j++) begin
        older_nxt[j][alloc_idx] = entry_valid[j] && (j != int'(alloc_idx));
        older_nxt[alloc_idx][j] = 1'b0;
      end
    end
  end

  // Age matrix register; reset and flush wipe all age history.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      older <= '0;
    end else begin
      older <= older_nxt;
    end
  end

  // In-flight bits drop when the RS frees a slot, are set on a lane accept,
  // and a reallocation of a slot always starts it out of flight.
  always_comb begin
    inflight_nxt = inflight & entry_valid;
    for (int l = 0; l < SCHED_LANES; l++) begin
      if (lane_accept[l]) begin
        inflight_nxt[lane_idx[l]] = 1'b1;
      end
    end
    if (alloc) begin
      inflight_nxt[alloc_idx] = 1'b0;
    end
  end

  // In-flight register; a flush discards any accept in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight_nxt;
    end
  end

  for (genvar g = 0; g < SCHED_LANES; g++) begin : g_lane
    logic [0:0]       state;
    logic [IDX_W-1:0] idx_q;
    logic [SIZE-1:0]  lane_sel;
    logic [SIZE-1:0]  held;
    logic [SIZE-1:0]  cand;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    // entry_cmp partitions the RS between the two lanes.
    assign lane_sel = (g == int'(lane_cmp)) ? entry_cmp : ~entry_cmp;

    // The entry currently on offer must not be picked a second time.
    always_comb begin
      held = '0;
      if (state == ST_OFFER) begin
        held[idx_q] = 1'b1;
      end
    end

    assign cand = entry_valid & entry_ready & ~inflight & lane_sel & ~held;

    oldest_picker #(
      .SIZE  (SIZE),
      .IDX_W (IDX_W)
    ) u_picker (
      .cand  (cand),
      .older (older),
      .any   (pick_any),
      .idx   (pick_idx)
    );

    // An accept only counts while the offered entry is still live in the RS.
    assign lane_accept[g] = (state == ST_OFFER) && entry_valid[idx_q] && lane_ready[g];
    assign lane_valid[g]  = (state == ST_OFFER);
    assign lane_idx[g]    = idx_q;

    // Lane offer state machine: hold the offer until accepted or withdrawn,
    // and chain straight into the next pick on an accept.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state <= ST_IDLE;
        idx_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pick_any) begin
              state <= ST_OFFER;
              idx_q <= pick_idx;
            end
          end
          ST_OFFER: begin
            if (!entry_valid[idx_q]) begin
              state <= ST_IDLE;
            end else if (lane_ready[g]) begin
              if (pick_any) begin
                idx_q <= pick_idx;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end : g_lane

  assign alu_issue_valid = lane_valid[int'(lane_alu)];
  assign alu_issue_idx   = lane_idx[int'(lane_alu)];
  assign cmp_issue_valid = lane_valid[int'(lane_cmp)];
  assign cmp_issue_idx   = lane_idx[int'(lane_cmp)];

`ifdef SCHED_PERF_EN
  // Event counters survive flush and wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued    <= '0;
      perf_alu_stall <= '0;
      perf_cmp_stall <= '0;
    end else begin
      if (!flush) begin
        perf_issued <= perf_issued + 32'(lane_accept[int'(lane_alu)])
                                   + 32'(lane_accept[int'(lane_cmp)]);
      end
      if (lane_valid[int'(lane_alu)] && !lane_ready[int'(lane_alu)]) begin
        perf_alu_stall <= perf_alu_stall + 32'd1;
      end
      if (lane_valid[int'(lane_cmp)] && !lane_ready[int'(lane_cmp)]) begin
        perf_cmp_stall <= perf_cmp_stall + 32'd1;
      end
    end
  end
`endif

endmodule : rs_issue_scheduler

`default_nettype wire
